// File: rtl/priority_mixer.sv
// priority_mixer: layer priority mixer with a 16-entry CPU register file.
// Two-stage pixel pipeline advanced on ce_pixel. Stage 1 latches each layer's
// colour and effective priority. Stage 2 picks the winner, or the backdrop
// when no layer has a priority.
module priority_mixer (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pixel,
    input  logic [7:0]  Din,
    output logic [7:0]  Dout,
    input  logic [3:0]  VA,
    input  logic        RWn,
    input  logic        CSn,
    output logic        DACKn,
    input  logic [14:0] BG0,
    input  logic [14:0] BG1,
    input  logic [14:0] FG0,
    input  logic [13:0] OB,
    input  logic        HSYn_in,
    input  logic        VSYn_in,
    output logic [14:0] SC,
    output logic        HSYn,
    output logic        VSYn
);

    logic [7:0]  r_regs [16];
    logic [7:0]  r_dout;
    logic        r_csn_d;
    logic        r_dackn;

    logic [13:0] r_s1_bg0, r_s1_bg1, r_s1_fg0;
    logic [11:0] r_s1_ob;
    logic [3:0]  r_s1_bg0_pri, r_s1_bg1_pri, r_s1_fg0_pri, r_s1_ob_pri;
    logic        r_s1_hsyn, r_s1_vsyn;

    logic [14:0] r_sc;
    logic        r_hsyn, r_vsyn;

    logic        w_access;
    logic [3:0]  w_bg0_pri, w_bg1_pri, w_fg0_pri, w_ob_pri, w_ob_nib;
    logic [3:0]  w_best;
    logic [14:0] w_sc_next;
    logic        w_unused_bits;

    // An access starts only on a genuine high-to-low CSn transition; the
    // history resets to 0 so a CSn held low through reset never qualifies.
    assign w_access = ~CSn & r_csn_d;

    // Bit 14 of the tile inputs is not forwarded to SC.
    assign w_unused_bits = ^{BG0[14], BG1[14], FG0[14]};

    // CPU side: edge history, register write/read and acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
            r_dout  <= 8'h00;
            r_csn_d <= 1'b0;
            r_dackn <= 1'b1;
        end else begin
            r_csn_d <= CSn;
            if (w_access) begin
                if (RWn) r_dout <= r_regs[VA];
                else     r_regs[VA] <= Din;
            end
            if (CSn)           r_dackn <= 1'b1;
            else if (w_access) r_dackn <= 1'b0;
        end
    end

    // DACKn is released combinationally so it is never low while CSn is high.
    assign DACKn = r_dackn | CSn;
    assign Dout  = r_dout;

    // Sprite priority nibble chosen by the sprite's priority group.
    always_comb begin
        w_ob_nib = 4'h0;
        case (OB[13:12])
            2'd0: w_ob_nib = r_regs[1][3:0];
            2'd1: w_ob_nib = r_regs[1][7:4];
            2'd2: w_ob_nib = r_regs[2][3:0];
            2'd3: w_ob_nib = r_regs[2][7:4];
            default: w_ob_nib = 4'h0;
        endcase
    end

    assign w_bg0_pri = (BG0[3:0] != 4'h0 && r_regs[4][0]) ? r_regs[0][3:0] : 4'h0;
    assign w_bg1_pri = (BG1[3:0] != 4'h0 && r_regs[4][1]) ? r_regs[0][7:4] : 4'h0;
    assign w_fg0_pri = (FG0[3:0] != 4'h0 && r_regs[4][2]) ? r_regs[3][3:0] : 4'h0;
    assign w_ob_pri  = (OB[3:0]  != 4'h0 && r_regs[4][3]) ? w_ob_nib       : 4'h0;

    // Winner select: later layers take ties, giving sprite > FG0 > BG1 > BG0.
    always_comb begin
        w_best    = 4'h0;
        w_sc_next = 15'h4000;
        if (r_s1_bg0_pri != 4'h0) begin
            w_best    = r_s1_bg0_pri;
            w_sc_next = {1'b0, r_s1_bg0};
        end
        if (r_s1_bg1_pri != 4'h0 && r_s1_bg1_pri >= w_best) begin
            w_best    = r_s1_bg1_pri;
            w_sc_next = {1'b0, r_s1_bg1};
        end
        if (r_s1_fg0_pri != 4'h0 && r_s1_fg0_pri >= w_best) begin
            w_best    = r_s1_fg0_pri;
            w_sc_next = {1'b0, r_s1_fg0};
        end
        if (r_s1_ob_pri != 4'h0 && r_s1_ob_pri >= w_best) begin
            w_best    = r_s1_ob_pri;
            w_sc_next = {3'b000, r_s1_ob};
        end
    end

    // Pixel pipeline: both stages advance only on ce_pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_bg0     <= '0;
            r_s1_bg1     <= '0;
            r_s1_fg0     <= '0;
            r_s1_ob      <= '0;
            r_s1_bg0_pri <= '0;
            r_s1_bg1_pri <= '0;
            r_s1_fg0_pri <= '0;
            r_s1_ob_pri  <= '0;
            r_s1_hsyn    <= 1'b1;
            r_s1_vsyn    <= 1'b1;
            r_sc         <= 15'h4000;
            r_hsyn       <= 1'b1;
            r_vsyn       <= 1'b1;
        end else if (ce_pixel) begin
            r_s1_bg0     <= BG0[13:0];
            r_s1_bg1     <= BG1[13:0];
            r_s1_fg0     <= FG0[13:0];
            r_s1_ob      <= OB[11:0];
            r_s1_bg0_pri <= w_bg0_pri;
            r_s1_bg1_pri <= w_bg1_pri;
            r_s1_fg0_pri <= w_fg0_pri;
            r_s1_ob_pri  <= w_ob_pri;
            r_s1_hsyn    <= HSYn_in;
            r_s1_vsyn    <= VSYn_in;
            r_sc         <= w_sc_next;
            r_hsyn       <= r_s1_hsyn;
            r_vsyn       <= r_s1_vsyn;
        end
    end

    assign SC   = r_sc;
    assign HSYn = r_hsyn;
    assign VSYn = r_vsyn;

endmodule

// File: tb/tb_priority_mixer.sv
// Directed bench for priority_mixer: vector table for mixing, plus hand
// sequences for CPU handshake, pipeline timing and reset-mid-access.
module tb_priority_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_pixel;
    logic [7:0]  Din;
    logic [7:0]  Dout;
    logic [3:0]  VA;
    logic        RWn;
    logic        CSn;
    logic        DACKn;
    logic [14:0] BG0, BG1, FG0;
    logic [13:0] OB;
    logic        HSYn_in, VSYn_in;
    logic [14:0] SC;
    logic        HSYn, VSYn;

    int n_pass  = 0;
    int n_total = 0;

    priority_mixer dut (
        .clk(clk), .reset(reset), .ce_pixel(ce_pixel),
        .Din(Din), .Dout(Dout), .VA(VA), .RWn(RWn), .CSn(CSn), .DACKn(DACKn),
        .BG0(BG0), .BG1(BG1), .FG0(FG0), .OB(OB),
        .HSYn_in(HSYn_in), .VSYn_in(VSYn_in),
        .SC(SC), .HSYn(HSYn), .VSYn(VSYn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r0, r1, r2, r3, r4;
        logic [14:0] bg0, bg1, fg0;
        logic [13:0] ob;
        logic [14:0] exp_sc;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        CSn = 1'b0; RWn = 1'b0; VA = a; Din = d;
        @(negedge clk);
        CSn = 1'b1; RWn = 1'b1;
    endtask

    task automatic cpu_read(input logic [3:0] a);
        @(negedge clk);
        CSn = 1'b0; RWn = 1'b1; VA = a;
        @(negedge clk);
        CSn = 1'b1;
    endtask

    task automatic pix(input logic [14:0] b0, input logic [14:0] b1, input logic [14:0] f0,
                       input logic [13:0] o, input logic h, input logic v);
        @(negedge clk);
        BG0 = b0; BG1 = b1; FG0 = f0; OB = o; HSYn_in = h; VSYn_in = v;
        ce_pixel = 1'b1;
        @(negedge clk);
        ce_pixel = 1'b0;
        #1;
    endtask

    initial begin
        //            r0     r1     r2     r3     r4     bg0       bg1       fg0       ob        exp
        vecs[0]  = '{8'h21, 8'h00, 8'h00, 8'h00, 8'h03, 15'h0011, 15'h0022, 15'h0000, 14'h0000, 15'h0022};
        vecs[1]  = '{8'h21, 8'h00, 8'h00, 8'h00, 8'h03, 15'h0011, 15'h0020, 15'h0000, 14'h0000, 15'h0011};
        vecs[2]  = '{8'h55, 8'h05, 8'h00, 8'h00, 8'h0F, 15'h0011, 15'h0000, 15'h0000, 14'h0123, 15'h0123};
        vecs[3]  = '{8'h55, 8'h05, 8'h00, 8'h00, 8'h0F, 15'h0010, 15'h0020, 15'h0030, 14'h0120, 15'h4000};
        vecs[4]  = '{8'h21, 8'h00, 8'h00, 8'h07, 8'h0F, 15'h0000, 15'h0022, 15'h7ABC, 14'h0000, 15'h3ABC};
        vecs[5]  = '{8'h21, 8'h00, 8'h00, 8'h07, 8'h00, 15'h0011, 15'h0022, 15'h7ABC, 14'h0123, 15'h4000};
        vecs[6]  = '{8'h21, 8'h00, 8'h90, 8'h00, 8'h08, 15'h0011, 15'h0000, 15'h0000, 14'h3456, 15'h0456};
        vecs[7]  = '{8'h41, 8'h00, 8'h03, 8'h00, 8'h0F, 15'h0000, 15'h0022, 15'h0000, 14'h2345, 15'h0022};
        vecs[8]  = '{8'h30, 8'h00, 8'h00, 8'h03, 8'h0F, 15'h0000, 15'h0022, 15'h0015, 14'h0000, 15'h0015};
        vecs[9]  = '{8'h22, 8'h00, 8'h00, 8'h00, 8'h03, 15'h0011, 15'h0022, 15'h0000, 14'h0000, 15'h0022};
        vecs[10] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 15'h4011, 15'h0000, 15'h0000, 14'h0000, 15'h0011};
        vecs[11] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h09, 15'h0011, 15'h0000, 15'h0000, 14'h0123, 15'h0011};

        reset = 1'b1; ce_pixel = 1'b0; Din = 8'h00; VA = 4'h0; RWn = 1'b1; CSn = 1'b1;
        BG0 = '0; BG1 = '0; FG0 = '0; OB = '0; HSYn_in = 1'b1; VSYn_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sc", 32'(SC), 32'h4000);
        chk("rst_dackn", 32'(DACKn), 32'h1);
        chk("rst_hsyn", 32'(HSYn), 32'h1);
        chk("rst_vsyn", 32'(VSYn), 32'h1);
        chk("rst_dout", 32'(Dout), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Write/readback and DACKn timing.
        cpu_write(4'h0, 8'h21);
        cpu_write(4'h4, 8'h0F);
        chk("dout_hold_after_write", 32'(Dout), 32'h00);
        @(negedge clk);
        CSn = 1'b0; RWn = 1'b1; VA = 4'h0;
        #1;
        chk("dackn_before_edge", 32'(DACKn), 32'h1);
        @(negedge clk); #1;
        chk("dackn_after_edge", 32'(DACKn), 32'h0);
        chk("read_r0", 32'(Dout), 32'h21);
        @(negedge clk); @(negedge clk); #1;
        chk("dackn_held_low", 32'(DACKn), 32'h0);
        CSn = 1'b1;
        #1;
        chk("dackn_rise_with_csn", 32'(DACKn), 32'h1);

        cpu_write(4'h5, 8'hA5);
        cpu_read(4'h5);
        chk("read_r5", 32'(Dout), 32'hA5);

        // One long CSn low performs exactly one write.
        @(negedge clk);
        CSn = 1'b0; RWn = 1'b0; VA = 4'h6; Din = 8'h11;
        @(negedge clk);
        Din = 8'h22;
        repeat (3) @(negedge clk);
        CSn = 1'b1; RWn = 1'b1;
        cpu_read(4'h6);
        chk("single_write_per_access", 32'(Dout), 32'h11);

        // Mixing vectors: two ce_pixel from sample to SC.
        for (int i = 0; i < 12; i++) begin
            cpu_write(4'h0, vecs[i].r0);
            cpu_write(4'h1, vecs[i].r1);
            cpu_write(4'h2, vecs[i].r2);
            cpu_write(4'h3, vecs[i].r3);
            cpu_write(4'h4, vecs[i].r4);
            pix(vecs[i].bg0, vecs[i].bg1, vecs[i].fg0, vecs[i].ob, 1'b1, 1'b1);
            pix(vecs[i].bg0, vecs[i].bg1, vecs[i].fg0, vecs[i].ob, 1'b1, 1'b1);
            chk($sformatf("vec%0d_sc", i), 32'(SC), 32'(vecs[i].exp_sc));
        end

        // Sync latency, alignment with SC, and stalls without ce_pixel.
        cpu_write(4'h0, 8'h01);
        cpu_write(4'h4, 8'h01);
        pix(15'h0011, 15'h0, 15'h0, 14'h0, 1'b0, 1'b1);
        chk("hsyn_after_1ce", 32'(HSYn), 32'h1);
        pix(15'h0000, 15'h0, 15'h0, 14'h0, 1'b1, 1'b1);
        chk("hsyn_after_2ce", 32'(HSYn), 32'h0);
        chk("sc_aligned_hsyn", 32'(SC), 32'h0011);
        pix(15'h0000, 15'h0, 15'h0, 14'h0, 1'b1, 1'b1);
        chk("hsyn_pulse_end", 32'(HSYn), 32'h1);
        chk("sc_backdrop", 32'(SC), 32'h4000);
        @(negedge clk);
        BG0 = 15'h0011; HSYn_in = 1'b0; VSYn_in = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("stall_sc", 32'(SC), 32'h4000);
        chk("stall_hsyn", 32'(HSYn), 32'h1);
        chk("stall_vsyn", 32'(VSYn), 32'h1);
        pix(15'h0011, 15'h0, 15'h0, 14'h0, 1'b0, 1'b0);
        chk("stall_stage1_sc", 32'(SC), 32'h4000);
        chk("stall_stage1_hsyn", 32'(HSYn), 32'h1);
        pix(15'h0011, 15'h0, 15'h0, 14'h0, 1'b1, 1'b1);
        chk("post_stall_sc", 32'(SC), 32'h0011);
        chk("post_stall_vsyn", 32'(VSYn), 32'h0);

        // A write in the same clk as ce_pixel does not affect that sample.
        cpu_write(4'h0, 8'h21);
        cpu_write(4'h4, 8'h01);
        @(negedge clk);
        BG0 = 15'h0011; BG1 = 15'h0022; FG0 = '0; OB = '0; HSYn_in = 1'b1; VSYn_in = 1'b1;
        CSn = 1'b0; RWn = 1'b0; VA = 4'h4; Din = 8'h03; ce_pixel = 1'b1;
        @(negedge clk);
        CSn = 1'b1; RWn = 1'b1; ce_pixel = 1'b0;
        pix(15'h0011, 15'h0022, 15'h0, 14'h0, 1'b1, 1'b1);
        chk("coincident_write_old", 32'(SC), 32'h0011);
        pix(15'h0011, 15'h0022, 15'h0, 14'h0, 1'b1, 1'b1);
        chk("coincident_write_new", 32'(SC), 32'h0022);

        // Reset in the middle of an acknowledged read.
        @(negedge clk);
        CSn = 1'b0; RWn = 1'b1; VA = 4'h5;
        @(negedge clk); #1;
        chk("mid_access_dackn", 32'(DACKn), 32'h0);
        chk("mid_access_dout", 32'(Dout), 32'hA5);
        reset = 1'b1;
        #1;
        chk("abort_dackn", 32'(DACKn), 32'h1);
        chk("abort_sc", 32'(SC), 32'h4000);
        chk("abort_dout", 32'(Dout), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("no_reack_after_reset", 32'(DACKn), 32'h1);
        chk("no_read_after_reset", 32'(Dout), 32'h00);
        CSn = 1'b1;
        cpu_write(4'h5, 8'h3C);
        cpu_read(4'h0);
        chk("r0_cleared", 32'(Dout), 32'h00);
        cpu_read(4'h5);
        chk("post_reset_access", 32'(Dout), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
